// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: shared types and helpers for the warmboot controller
package boot_ctrl_pkg;
  typedef logic [1:0] image_t;
  typedef enum logic [1:0] {IDLE, ARMED, BOOT} boot_state_t;
  // counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/boot_debounce.sv
// boot_debounce: 2-FF synchroniser plus saturating qualify counter
//   clk, rst : clock, synchronous active-high reset
//   i_raw    : raw asynchronous level input
//   o_qual   : high while the synced input has been high THRESHOLD consecutive cycles
module boot_debounce
  import boot_ctrl_pkg::*;
#(
  parameter int THRESHOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_qual
);
  localparam int W = cnt_w(THRESHOLD + 1);
  logic [1:0]   r_sync;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_cnt  <= !r_sync[1] ? '0 : (r_cnt == W'(THRESHOLD)) ? r_cnt : r_cnt + 1'b1;
    end
  end
  assign o_qual = (r_cnt == W'(THRESHOLD));
endmodule

// File: rtl/boot_ctrl.sv
// boot_ctrl: warmboot controller arming a cancellable boot from debounced requests
//   clk, rst  : clk_48 domain clock, synchronous active-high reset
//   req_i     : N_SRC raw boot requests, lowest index has priority
//   btn_i     : raw user button, long press requests BTN_IMAGE
//   inhibit_i : blocks arming and cancels a pending boot
//   boot_o    : sticky SB_WARMBOOT BOOT strobe
//   image_o   : SB_WARMBOOT S1:S0
//   armed_o   : high during the grace period
//   led_o     : blink feedback, only driven when BOOT_CTRL_LED_EN is defined
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int                 N_SRC             = 3,
  parameter logic [2*N_SRC-1:0] SRC_IMAGE         = '0,
  parameter image_t             BTN_IMAGE         = 2'b00,
  parameter image_t             DEFAULT_IMAGE     = 2'b01,
  parameter int                 DEBOUNCE_CYCLES   = 480000,
  parameter int                 LONG_PRESS_CYCLES = 96000000,
  parameter int                 ARM_CYCLES        = 4800000,
  parameter int                 BLINK_CYCLES      = 2400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req_i,
  input  logic             btn_i,
  input  logic             inhibit_i,
  output logic             boot_o,
  output logic [1:0]       image_o,
  output logic             armed_o,
  output logic             led_o
);
  localparam int AW = cnt_w(ARM_CYCLES);
  if (N_SRC < 1 || N_SRC > 8 || DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 ||
      ARM_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
    $error("boot_ctrl: parameter out of range");
  end
  logic [N_SRC-1:0] w_qual;
  logic             w_btn_qual;
  image_t           w_sel;
  boot_state_t      r_state, w_next;
  image_t           r_image;
  logic [AW-1:0]    r_arm;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    boot_debounce #(.THRESHOLD(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .i_raw(req_i[i]), .o_qual(w_qual[i]));
  end
  boot_debounce #(.THRESHOLD(LONG_PRESS_CYCLES)) u_btn (
    .clk(clk), .rst(rst), .i_raw(btn_i), .o_qual(w_btn_qual));
  // descending scan so the lowest qualified source overrides; button only when no source
  always_comb begin
    w_sel = BTN_IMAGE;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (w_qual[k]) w_sel = SRC_IMAGE[2*k +: 2];
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (((|w_qual || w_btn_qual) && !inhibit_i) ? ARMED : IDLE) :
             (r_state == ARMED) ? (inhibit_i ? IDLE : (r_arm == AW'(ARM_CYCLES - 1)) ? BOOT : ARMED) :
             BOOT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_image <= DEFAULT_IMAGE;
      r_arm   <= '0;
    end else begin
      r_state <= w_next;
      r_arm   <= (r_state == ARMED && w_next == ARMED) ? r_arm + 1'b1 : '0;
      r_image <= (r_state == IDLE && w_next == ARMED) ? w_sel :
                 (w_next == IDLE) ? DEFAULT_IMAGE : r_image;
    end
  end
  assign boot_o  = (r_state == BOOT);
  assign armed_o = (r_state == ARMED);
  assign image_o = r_image;
`ifdef BOOT_CTRL_LED_EN
  localparam int BW = cnt_w(BLINK_CYCLES);
  logic [BW-1:0] r_blink;
  logic          r_led;
  logic          w_enter;
  logic          w_wrap;
  assign w_enter = (r_state != ARMED) && (w_next == ARMED);
  assign w_wrap  = (r_blink == BW'(BLINK_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= '0;
      r_led   <= 1'b0;
    end else begin
      r_blink <= (w_enter || w_wrap) ? '0 : r_blink + 1'b1;
      r_led   <= (w_next == BOOT) ? 1'b1 : (w_next == IDLE) ? 1'b0 :
                 w_enter ? 1'b1 : w_wrap ? ~r_led : r_led;
    end
  end
  assign led_o = r_led;
`else
  assign led_o = 1'b0;
`endif
endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: scoreboard bench for boot_ctrl output-change events
module tb_boot_ctrl;
  localparam int BLINK = 2;
`ifdef BOOT_CTRL_LED_EN
  localparam bit LED_ON = 1'b1;
`else
  localparam bit LED_ON = 1'b0;
`endif
  // v = {boot, armed, image[1:0], led}
  typedef struct packed {
    int         cyc;
    logic [4:0] v;
  } ev_t;
  localparam logic [4:0] RST_V = 5'b00010;
  bit         clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_i = '0;
  logic       btn_i = 1'b0;
  logic       inhibit_i = 1'b0;
  logic       boot_o, armed_o, led_o;
  logic [1:0] image_o;
  int         cyc = 0;
  int         base = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        q[$];
  logic [4:0] exp_last = 'x;
  logic       done = 1'b0;
  logic       final_done = 1'b0;
  logic [4:0] prev = 'x;
  logic [4:0] obs;
  ev_t        e;

  boot_ctrl #(
    .N_SRC(3), .SRC_IMAGE({2'b11, 2'b10, 2'b00}), .BTN_IMAGE(2'b00), .DEFAULT_IMAGE(2'b01),
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .ARM_CYCLES(8), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .btn_i(btn_i), .inhibit_i(inhibit_i),
    .boot_o(boot_o), .image_o(image_o), .armed_o(armed_o), .led_o(led_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [4:0] v);
    q.push_back('{c, v});
    exp_last = v;
  endtask

  // mode: 0 cancelled at te, 1 boots at te, 2 ends externally (reset)
  task automatic arm_seq(input int ta, input int te, input logic [1:0] img, input int mode);
    logic l;
    l = LED_ON;
    push(base + ta, {2'b01, img, l});
    if (LED_ON)
      for (int t = ta + BLINK; t < te; t += BLINK) begin
        l = ~l;
        push(base + t, {2'b01, img, l});
      end
    if (mode == 1) push(base + te, {2'b10, img, LED_ON});
    else if (mode == 0) push(base + te, {2'b00, 2'b01, 1'b0});
  endtask

  task automatic start(input logic [2:0] r, input logic b);
    rst = 1'b0;
    req_i = r;
    btn_i = b;
    inhibit_i = 1'b0;
    base = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = '0;
    btn_i = 1'b0;
    inhibit_i = 1'b0;
    if (exp_last !== RST_V) push(cyc + 1, RST_V);
    run(2);
  endtask

  always @(negedge clk) begin
    obs = {boot_o, armed_o, image_o, led_o};
    if (obs !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d outputs %b, required unchanged %b", cyc, obs, prev);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || obs !== e.v) begin
          errors++;
          $display("FAIL event: got cycle %0d outputs(boot,armed,image,led)=%b, required cycle %0d outputs %b",
                   cyc, obs, e.cyc, e.v);
        end
      end
      prev = obs;
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL pending_events: %0d outstanding, required 0 (next cycle %0d outputs %b)",
                 q.size(), q[0].cyc, q[0].v);
      end
    end
  end

  initial begin
    push(1, RST_V);
    run(3);
    // source 1 held: arm at 7, boot at 15
    start(3'b010, 1'b0);
    arm_seq(7, 15, 2'b10, 1);
    run(20);
    do_reset();
    // source 0 glitches low once: count restarts, arm at 11
    start(3'b001, 1'b0);
    arm_seq(11, 19, 2'b00, 1);
    run(3);
    req_i = 3'b000;
    run(1);
    req_i = 3'b001;
    run(24);
    do_reset();
    // source 2 beats the button on the same cycle
    start(3'b100, 1'b1);
    arm_seq(7, 15, 2'b11, 1);
    run(18);
    do_reset();
    // button held 15 cycles: one short of qualifying
    start(3'b000, 1'b1);
    run(15);
    btn_i = 1'b0;
    run(10);
    do_reset();
    // button long press qualifies: arm at 19 with button image
    start(3'b000, 1'b1);
    arm_seq(19, 27, 2'b00, 1);
    run(30);
    do_reset();
    // inhibit at arm count 5 cancels; held-qual rearms when inhibit drops
    start(3'b010, 1'b0);
    arm_seq(7, 13, 2'b10, 0);
    arm_seq(20, 28, 2'b10, 1);
    run(12);
    inhibit_i = 1'b1;
    run(7);
    inhibit_i = 1'b0;
    run(12);
    do_reset();
    // inhibit on the final armed cycle still cancels
    start(3'b010, 1'b0);
    arm_seq(7, 15, 2'b10, 0);
    arm_seq(16, 24, 2'b10, 1);
    run(14);
    inhibit_i = 1'b1;
    run(1);
    inhibit_i = 1'b0;
    run(12);
    do_reset();
    // reset mid-armed, then re-arm and reset from boot
    start(3'b010, 1'b0);
    arm_seq(7, 11, 2'b10, 2);
    run(10);
    do_reset();
    start(3'b010, 1'b0);
    arm_seq(7, 15, 2'b10, 1);
    run(18);
    do_reset();
    done = 1'b1;
    run(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
